// File: rtl/vga_frame_monitor.sv
// Recovers visible-pixel coordinates from a sampled VGA stream and checks frame geometry.
// Outputs are registered one CLOCK_50 edge after the pixel strobe. No backpressure: the consumer must keep up.
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          vga_clk,
    input  logic          vga_hs,
    input  logic          vga_vs,
    input  logic          vga_blank,
    input  logic [9:0]    vga_r,
    input  logic [9:0]    vga_g,
    input  logic [9:0]    vga_b,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [29:0]   pix_rgb,
    output logic          frame_done,
    output logic          locked,
    output logic          err_geom,
    output logic [15:0]   frame_count
);

    typedef enum logic {SEEK, CAPTURE} state_t;

    typedef struct packed {
        logic        clk;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [29:0] rgb;
    } vga_smp_t;

    vga_smp_t s1_q;
    logic     s2_clk_q;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            prev_vs_q, prev_vs_d;
    logic            prev_act_q, prev_act_d;
    logic            pix_valid_q, pix_valid_d;
    logic [XW-1:0]   pix_x_q, pix_x_d;
    logic [YW-1:0]   pix_y_q, pix_y_d;
    logic [29:0]     pix_rgb_q, pix_rgb_d;
    logic            frame_done_q, frame_done_d;
    logic            locked_q, locked_d;
    logic            err_geom_q, err_geom_d;
    logic [15:0]     frame_count_q, frame_count_d;

    logic strobe, vs_fall;
    logic unused_hs;

    // HS is sampled alongside the rest of the bus but geometry is derived from blanking alone.
    assign unused_hs = s1_q.hs;
    assign strobe    = s1_q.clk & ~s2_clk_q;
    assign vs_fall   = ~s1_q.vs & prev_vs_q;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        prev_vs_d     = prev_vs_q;
        prev_act_d    = prev_act_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_rgb_d     = pix_rgb_q;
        frame_done_d  = 1'b0;
        locked_d      = locked_q;
        err_geom_d    = err_geom_q;
        frame_count_d = frame_count_q;
        if (strobe) begin
            prev_vs_d  = s1_q.vs;
            prev_act_d = s1_q.blank;
            if (vs_fall) begin
                if (state_q == CAPTURE) begin
                    if (y_q == YW'(V_ACTIVE)) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        locked_d      = 1'b1;
                    end else begin
                        err_geom_d = 1'b1;
                        locked_d   = 1'b0;
                    end
                end
                state_d = CAPTURE;
                x_d     = '0;
                y_d     = '0;
            end else if (state_q == CAPTURE && !s1_q.blank && prev_act_q) begin
                if (x_q == XW'(H_ACTIVE)) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    err_geom_d = 1'b1;
                    locked_d   = 1'b0;
                    state_d    = SEEK;
                end
            end
            // The pixel is judged against coordinates already updated by a same-strobe VS edge.
            if (state_d == CAPTURE && s1_q.blank) begin
                if (x_d == XW'(H_ACTIVE) || y_d == YW'(V_ACTIVE)) begin
                    err_geom_d = 1'b1;
                    locked_d   = 1'b0;
                    state_d    = SEEK;
                end else begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = x_d;
                    pix_y_d     = y_d;
                    pix_rgb_d   = s1_q.rgb;
                    x_d         = x_d + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s1_q          <= '0;
            s2_clk_q      <= 1'b0;
            state_q       <= SEEK;
            x_q           <= '0;
            y_q           <= '0;
            prev_vs_q     <= 1'b0;
            prev_act_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            err_geom_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            s1_q          <= '{clk: vga_clk, hs: vga_hs, vs: vga_vs, blank: vga_blank,
                               rgb: {vga_r, vga_g, vga_b}};
            s2_clk_q      <= s1_q.clk;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            prev_vs_q     <= prev_vs_d;
            prev_act_q    <= prev_act_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            err_geom_q    <= err_geom_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_done  = frame_done_q;
    assign locked      = locked_q;
    assign err_geom    = err_geom_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: small raster (8x4) driven synchronously to CLOCK_50, outputs
// compared every cycle against a rule-level model delayed by the DUT's two-edge pipeline.
module tb_vga_frame_monitor;

    localparam int HA = 8;
    localparam int VA = 4;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b1;
    logic        vga_clk  = 1'b0;
    logic        vga_hs   = 1'b1;
    logic        vga_vs   = 1'b1;
    logic        vga_blank = 1'b0;
    logic [9:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        pix_valid, frame_done, locked, err_geom;
    logic [9:0]  pix_x, pix_y;
    logic [29:0] pix_rgb;
    logic [15:0] frame_count;

    vga_frame_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .XW(10), .YW(10)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .vga_clk(vga_clk), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_blank(vga_blank), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .locked(locked), .err_geom(err_geom), .frame_count(frame_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit          pv;
        int          x;
        int          y;
        logic [29:0] rgb;
        bit          fd;
        bit          lk;
        bit          er;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   pv_seen = 0, order_idx = 0;
    bit   order_on = 0, jit = 0;

    // Model state: capturing flag, raster position, previous-strobe flags, status.
    bit m_cap, m_pvs, m_pact, m_pclk, m_lk, m_er;
    int mx, my, m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_t z;
        m_cap = 0; m_pvs = 0; m_pact = 0; m_pclk = 0; m_lk = 0; m_er = 0;
        mx = 0; my = 0; m_cnt = 0;
        z = '{pv: 0, x: 0, y: 0, rgb: '0, fd: 0, lk: 0, er: 0, cnt: 0};
        q.delete();
        q.push_back(z);
        q.push_back(z);
    endtask

    task automatic model(input bit c, input bit vs, input bit bl, input logic [29:0] rgb,
                         output exp_t e);
        e = '{pv: 0, x: 0, y: 0, rgb: '0, fd: 0, lk: 0, er: 0, cnt: 0};
        if (c && !m_pclk) begin
            if (!vs && m_pvs) begin
                if (m_cap) begin
                    if (my == VA) begin
                        e.fd = 1; m_cnt = (m_cnt + 1) % 65536; m_lk = 1;
                    end else begin
                        m_er = 1; m_lk = 0;
                    end
                end
                m_cap = 1; mx = 0; my = 0;
            end else if (m_cap && !bl && m_pact) begin
                if (mx == HA) begin mx = 0; my++; end
                else begin m_er = 1; m_lk = 0; m_cap = 0; end
            end
            if (m_cap && bl) begin
                if (mx >= HA || my >= VA) begin m_er = 1; m_lk = 0; m_cap = 0; end
                else begin e.pv = 1; e.x = mx; e.y = my; e.rgb = rgb; mx++; end
            end
            m_pvs = vs; m_pact = bl;
        end
        m_pclk = c;
        e.lk = m_lk; e.er = m_er; e.cnt = m_cnt;
    endtask

    task automatic step(input bit c, input bit hs, input bit vs, input bit bl,
                        input logic [29:0] rgb);
        exp_t e, o;
        @(posedge CLOCK_50);
        #2;
        vga_clk = c; vga_hs = hs; vga_vs = vs; vga_blank = bl;
        {vga_r, vga_g, vga_b} = rgb;
        model(c, vs, bl, rgb, e);
        q.push_back(e);
        @(negedge CLOCK_50);
        o = q.pop_front();
        chk("pix_valid", 64'(pix_valid), 64'(o.pv));
        if (pix_valid && o.pv) begin
            chk("pix_x", 64'(pix_x), 64'(o.x));
            chk("pix_y", 64'(pix_y), 64'(o.y));
            chk("pix_rgb", 64'(pix_rgb), 64'(o.rgb));
        end
        chk("frame_done", 64'(frame_done), 64'(o.fd));
        chk("locked", 64'(locked), 64'(o.lk));
        chk("err_geom", 64'(err_geom), 64'(o.er));
        chk("frame_count", 64'(frame_count), 64'(o.cnt));
        if (pix_valid) begin
            pv_seen++;
            if (order_on) begin
                chk("raster_x", 64'(pix_x), 64'(order_idx % HA));
                chk("raster_y", 64'(pix_y), 64'((order_idx / HA) % VA));
                chk("raster_rgb", 64'(pix_rgb[19:0]),
                    64'({10'(order_idx % HA), 10'((order_idx / HA) % VA)}));
                order_idx++;
            end
        end
    endtask

    function automatic int w();
        return jit ? int'($urandom_range(1, 3)) : 1;
    endfunction

    task automatic pixel(input bit hs, input bit vs, input bit bl, input logic [29:0] rgb);
        int lo, hi;
        lo = w();
        hi = w();
        repeat (lo) step(1'b0, hs, vs, bl, rgb);
        repeat (hi) step(1'b1, hs, vs, bl, rgb);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        vga_clk = 1'b0;
        #1;
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_pix_x", 64'(pix_x), 64'd0);
        chk("rst_pix_y", 64'(pix_y), 64'd0);
        chk("rst_pix_rgb", 64'(pix_rgb), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_err_geom", 64'(err_geom), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        reset_model();
        repeat (2) @(posedge CLOCK_50);
        #2;
        resetn = 1'b1;
    endtask

    task automatic idle_line();
        for (int i = 0; i < HA + 2; i++) pixel(1'b1, 1'b1, 1'b0, '0);
    endtask

    // One frame: VS pulse (3 blank pixels), nlines lines of active + 2 blank pixels, 1 blank line.
    task automatic frame(input int nlines, input int short_line, input int short_len,
                         input int stall_line, input int rst_line);
        int len;
        for (int i = 0; i < 3; i++) pixel(1'b1, 1'b0, 1'b0, '0);
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? short_len : HA;
            for (int x = 0; x < len; x++) begin
                if (l == stall_line && x == 4) repeat (100) step(1'b0, 1'b1, 1'b1, 1'b1, '0);
                if (l == rst_line && x == 4) do_reset();
                pixel(1'b1, 1'b1, 1'b1, {10'($urandom_range(0, 1023)), 10'(x), 10'(l)});
            end
            pixel(1'b0, 1'b1, 1'b0, '0);
            pixel(1'b1, 1'b1, 1'b0, '0);
        end
        idle_line();
    endtask

    task automatic clean();
        frame(VA, -1, 0, -1, -1);
    endtask

    initial begin
        #3;
        do_reset();
        idle_line();

        order_on = 1;
        repeat (3) clean();
        order_on = 0;
        chk("clean_pixels", 64'(pv_seen), 64'd96);
        chk("clean_count", 64'(frame_count), 64'd2);
        chk("clean_locked", 64'(locked), 64'd1);
        chk("clean_err", 64'(err_geom), 64'd0);

        frame(VA, 2, 7, -1, -1);
        chk("short_err", 64'(err_geom), 64'd1);
        chk("short_locked", 64'(locked), 64'd0);
        repeat (2) clean();
        chk("short_recover_count", 64'(frame_count), 64'd4);
        chk("short_recover_locked", 64'(locked), 64'd1);
        chk("short_err_sticky", 64'(err_geom), 64'd1);

        frame(3, -1, 0, -1, -1);
        repeat (2) clean();
        chk("tall_count", 64'(frame_count), 64'd6);

        frame(VA, -1, 0, 1, -1);
        clean();
        chk("stall_count", 64'(frame_count), 64'd8);
        chk("stall_locked", 64'(locked), 64'd1);

        frame(VA, -1, 0, -1, 1);
        repeat (2) clean();
        chk("post_rst_count", 64'(frame_count), 64'd1);
        chk("post_rst_err", 64'(err_geom), 64'd0);

        force dut.frame_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        for (int i = 0; i < q.size(); i++) q[i].cnt = 16'hFFFF;
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        release dut.frame_count_q;
        clean();
        chk("wrap_count", 64'(frame_count), 64'd0);

        jit = 1;
        for (int f = 0; f < 30; f++) begin
            frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : VA,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                  int'($urandom_range(5, 7)),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
        end
        for (int i = 0; i < 3; i++) pixel(1'b1, 1'b0, 1'b0, '0);
        idle_line();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
